// File: rtl/mouse_pkg.sv
// Shared types and on-screen button regions for the mouse click path.
package mouse_pkg;

  typedef enum logic [1:0] {
    BTN_NONE,
    BTN_HIT,
    BTN_STAND,
    BTN_DEAL
  } click_id_t;

  typedef enum logic [1:0] {
    StIdle,
    StPressDb,
    StHeld,
    StRelDb
  } click_state_t;

  localparam logic [11:0] HIT_X0   = 12'd100;
  localparam logic [11:0] HIT_Y0   = 12'd600;
  localparam logic [11:0] HIT_W    = 12'd100;
  localparam logic [11:0] HIT_H    = 12'd50;

  localparam logic [11:0] STAND_X0 = 12'd250;
  localparam logic [11:0] STAND_Y0 = 12'd600;
  localparam logic [11:0] STAND_W  = 12'd100;
  localparam logic [11:0] STAND_H  = 12'd50;

  localparam logic [11:0] DEAL_X0  = 12'd400;
  localparam logic [11:0] DEAL_Y0  = 12'd600;
  localparam logic [11:0] DEAL_W   = 12'd100;
  localparam logic [11:0] DEAL_H   = 12'd50;

  // Half-open box test; region constants are small enough that x0+w never overflows.
  function automatic logic in_region(input logic [11:0] x, input logic [11:0] y,
                                     input logic [11:0] x0, input logic [11:0] y0,
                                     input logic [11:0] w, input logic [11:0] h);
    return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
  endfunction

endpackage

// File: rtl/mouse_click_decoder_if.sv
// Bus between the registered mouse stage / game FSM and the click decoder.
interface mouse_click_decoder_if;
  import mouse_pkg::*;

  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        right;
  logic        enable;
  logic        click_valid;
  click_id_t   click_id;
  logic        busy;

  modport master (
    output xpos, ypos, left, right, enable,
    input  click_valid, click_id, busy
  );

  modport slave (
    input  xpos, ypos, left, right, enable,
    output click_valid, click_id, busy
  );

endinterface

// File: rtl/button_hit_test.sv
// Combinational map from a screen coordinate to the game button under it.
module button_hit_test
  import mouse_pkg::*;
(
  input  logic [11:0] x,
  input  logic [11:0] y,
  output click_id_t   id
);

  always_comb begin
    id = BTN_NONE;
    if (in_region(x, y, HIT_X0, HIT_Y0, HIT_W, HIT_H)) begin
      id = BTN_HIT;
    end else if (in_region(x, y, STAND_X0, STAND_Y0, STAND_W, STAND_H)) begin
      id = BTN_STAND;
    end else if (in_region(x, y, DEAL_X0, DEAL_Y0, DEAL_W, DEAL_H)) begin
      id = BTN_DEAL;
    end
  end

endmodule

// File: rtl/mouse_click_decoder.sv
// Debounces the left button into single-cycle click events tagged with the button hit.
// Optional RIGHT_CANCEL_EN: right button during press debounce cancels the click.
module mouse_click_decoder
  import mouse_pkg::*;
#(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd65000
) (
  input logic                  clk,
  input logic                  rst,
  mouse_click_decoder_if.slave bus
);

  click_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [11:0]      x_q, x_d;
  logic [11:0]      y_q, y_d;
  logic             valid_q, valid_d;
  click_id_t        id_q, id_d;
  logic             busy_q;
  click_id_t        hit_id;
  logic             cancel;

`ifdef RIGHT_CANCEL_EN
  assign cancel = bus.right;
`else
  logic unused_right;
  assign cancel       = 1'b0;
  assign unused_right = bus.right;
`endif

  button_hit_test u_hit (
    .x  (x_q),
    .y  (y_q),
    .id (hit_id)
  );

  // The sample that enters PRESS_DB/REL_DB already counts as the first stable one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = 1'b0;
    id_d    = BTN_NONE;
    unique case (state_q)
      StIdle: begin
        if (bus.left && bus.enable) begin
          state_d = StPressDb;
          cnt_d   = CNT_W'(1);
          x_d     = bus.xpos;
          y_d     = bus.ypos;
        end
      end
      StPressDb: begin
        if (cancel) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (!bus.left) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q >= DEBOUNCE_CYCLES - CNT_W'(1)) begin
          state_d = StHeld;
          cnt_d   = DEBOUNCE_CYCLES;
          valid_d = 1'b1;
          id_d    = hit_id;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHeld: begin
        if (!bus.left) begin
          state_d = StRelDb;
          cnt_d   = CNT_W'(1);
        end
      end
      StRelDb: begin
        if (bus.left) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q >= DEBOUNCE_CYCLES - CNT_W'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      id_q    <= BTN_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign bus.click_valid = valid_q;
  assign bus.click_id    = id_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mouse_click_decoder.sv
// Directed + randomized bench for mouse_click_decoder against an event-level model.
module tb_mouse_click_decoder;
  import mouse_pkg::*;

  localparam int D = 4;
`ifdef RIGHT_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  mouse_click_decoder_if bus_if ();

  mouse_click_decoder #(
    .CNT_W           (16),
    .DEBOUNCE_CYCLES (16'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dut_pulses = 0;
  int m_pulses = 0;
  int pulse_cyc = 0;
  int last_id = 0;

  // Model: waiting for press, counting a press, or counting a release run.
  bit m_busy = 0;
  bit m_press = 0;
  int hi = 0;
  int lo = 0;
  int lx = 0;
  int ly = 0;
  bit m_valid = 0;
  click_id_t m_id = BTN_NONE;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic click_id_t model_hit(input int x, input int y);
    int x_lo [3] = '{100, 250, 400};
    int x_hi [3] = '{199, 349, 499};
    click_id_t ids [3] = '{BTN_HIT, BTN_STAND, BTN_DEAL};
    for (int i = 0; i < 3; i++) begin
      if (x >= x_lo[i] && x <= x_hi[i] && y >= 600 && y <= 649) return ids[i];
    end
    return BTN_NONE;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_press = 0;
    hi      = 0;
    lo      = 0;
    m_valid = 0;
    m_id    = BTN_NONE;
  endtask

  task automatic model_step(input bit l, input bit en, input bit r, input int x, input int y);
    m_valid = 0;
    m_id    = BTN_NONE;
    if (!m_busy) begin
      if (l && en) begin
        m_busy  = 1;
        m_press = 1;
        hi      = 1;
        lx      = x;
        ly      = y;
      end
    end else if (m_press) begin
      if (CANCEL && r) begin
        m_press = 0;
        lo      = 0;
      end else if (!l) begin
        m_busy  = 0;
        m_press = 0;
      end else begin
        hi++;
        if (hi == D) begin
          m_valid = 1;
          m_id    = model_hit(lx, ly);
          m_press = 0;
          lo      = 0;
        end
      end
    end else begin
      if (l) lo = 0;
      else begin
        lo++;
        if (lo == D) m_busy = 0;
      end
    end
  endtask

  // Compare process: every cycle, model advances on the edge and outputs are checked 1 ns later.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) model_reset();
      else model_step(bus_if.left, bus_if.enable, bus_if.right,
                      int'(bus_if.xpos), int'(bus_if.ypos));
      cyc++;
      #1;
      check("click_valid", int'(bus_if.click_valid), int'(m_valid));
      check("click_id", int'(bus_if.click_id), int'(m_id));
      check("busy", int'(bus_if.busy), int'(m_busy));
      if (bus_if.click_valid) begin
        dut_pulses++;
        pulse_cyc = cyc;
        last_id   = int'(bus_if.click_id);
      end
      if (m_valid) m_pulses++;
    end
  end

  task automatic cycles(input int n, input bit l, input int x, input int y);
    for (int i = 0; i < n; i++) begin
      bus_if.left = l;
      bus_if.xpos = 12'(x);
      bus_if.ypos = 12'(y);
      @(negedge clk);
    end
  endtask

  int p0, mp0, c0;
  int xs [15] = '{0, 99, 100, 150, 199, 200, 249, 250, 349, 350, 399, 400, 499, 500, 4095};
  int ys [7]  = '{599, 600, 625, 649, 650, 10, 4095};

  initial begin
    bus_if.left   = 0;
    bus_if.right  = 0;
    bus_if.enable = 1;
    bus_if.xpos   = '0;
    bus_if.ypos   = '0;
    repeat (3) @(negedge clk);
    rst = 1;
    cycles(2, 0, 0, 0);

    // Basic click on HIT
    p0 = dut_pulses; mp0 = m_pulses; c0 = cyc;
    cycles(1, 1, 150, 620);
    check("s1_busy_cycle1", int'(bus_if.busy), 1);
    cycles(9, 1, 150, 620);
    check("s1_pulses", dut_pulses - p0, 1);
    check("s1_model_pulses", m_pulses - mp0, 1);
    check("s1_id", last_id, int'(BTN_HIT));
    check("s1_latency", pulse_cyc - c0, 4);
    cycles(6, 0, 150, 620);
    check("s1_idle", int'(bus_if.busy), 0);

    // Glitchy press never reaches the threshold
    p0 = dut_pulses;
    cycles(3, 1, 300, 610);
    cycles(1, 0, 300, 610);
    check("s2_idle_a", int'(bus_if.busy), 0);
    cycles(3, 1, 300, 610);
    cycles(1, 0, 300, 610);
    check("s2_idle_b", int'(bus_if.busy), 0);
    check("s2_pulses", dut_pulses - p0, 0);

    // Cursor moves during debounce: latched position wins
    p0 = dut_pulses;
    cycles(1, 1, 450, 640);
    cycles(5, 1, 150, 620);
    check("s3_pulses", dut_pulses - p0, 1);
    check("s3_id", last_id, int'(BTN_DEAL));
    cycles(6, 0, 150, 620);

    // Click off every button, then a glitchy release
    p0 = dut_pulses; mp0 = m_pulses;
    cycles(5, 1, 10, 10);
    check("s4_pulses", dut_pulses - p0, 1);
    check("s4_id", last_id, int'(BTN_NONE));
    cycles(2, 0, 10, 10);
    cycles(1, 1, 10, 10);
    cycles(3, 0, 10, 10);
    check("s4_busy_3low", int'(bus_if.busy), 1);
    cycles(1, 0, 10, 10);
    check("s4_idle_4low", int'(bus_if.busy), 0);
    cycles(2, 0, 10, 10);
    check("s4_no_second", dut_pulses - p0, 1);
    check("s4_model", m_pulses - mp0, 1);

    // Asynchronous reset mid-press
    p0 = dut_pulses;
    cycles(2, 1, 150, 620);
    #2 rst = 0;
    #1;
    check("s5_async_busy", int'(bus_if.busy), 0);
    check("s5_async_valid", int'(bus_if.click_valid), 0);
    @(negedge clk);
    #2 rst = 1;
    c0 = cyc;
    cycles(6, 1, 150, 620);
    check("s5_pulses", dut_pulses - p0, 1);
    check("s5_latency", pulse_cyc - c0, 4);
    cycles(6, 0, 150, 620);

    // enable only gates the start of a press
    p0 = dut_pulses;
    bus_if.enable = 0;
    cycles(6, 1, 260, 620);
    check("s6_disabled", dut_pulses - p0, 0);
    cycles(2, 0, 260, 620);
    bus_if.enable = 1;
    cycles(1, 1, 260, 620);
    bus_if.enable = 0;
    cycles(5, 1, 260, 620);
    check("s6_late_disable", dut_pulses - p0, 1);
    check("s6_id", last_id, int'(BTN_STAND));
    bus_if.enable = 1;
    cycles(6, 0, 260, 620);

`ifdef RIGHT_CANCEL_EN
    p0 = dut_pulses;
    cycles(2, 1, 150, 620);
    bus_if.right = 1;
    cycles(1, 1, 150, 620);
    bus_if.right = 0;
    cycles(6, 1, 150, 620);
    check("s7_cancel", dut_pulses - p0, 0);
    cycles(4, 0, 150, 620);
    cycles(5, 1, 150, 620);
    check("s7_rearm", dut_pulses - p0, 1);
    cycles(6, 0, 150, 620);
`endif

    // Randomized run-length stimulus
    for (int seg = 0; seg < 700; seg++) begin
      bit l;
      int len;
      l             = 1'($urandom_range(0, 1));
      len           = $urandom_range(1, 7);
      bus_if.enable = ($urandom_range(0, 7) != 0);
      for (int k = 0; k < len; k++) begin
        bus_if.right = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 2) == 0) begin
          bus_if.xpos = 12'(xs[$urandom_range(0, 14)]);
          bus_if.ypos = 12'(ys[$urandom_range(0, 6)]);
        end
        bus_if.left = l;
        @(negedge clk);
      end
    end
    bus_if.right = 0;
    cycles(6, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mouse_click_decoder.md
Name: mouse_click_decoder

Overview:
- Sits directly downstream of the registered mouse stage. Consumes its position and button outputs and turns a raw left-button press into one debounced, single-cycle click event.
- Each click is tagged with the on-screen game button it landed in: HIT, STAND, DEAL or NONE.
- Feeds the blackjack game-control FSM, which acts only on click_valid pulses.

Parameters:
- DEBOUNCE_CYCLES, 16'd65000: consecutive cycles the button level must be stable to count as a press or release. Default is 1 ms at 65 MHz; must be >= 2.
- CNT_W, 16: width of the debounce counter.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset. One clock; reset is asynchronous and active-low (rst = 0 resets).
- xpos, input, 12: cursor x, registered upstream.
- ypos, input, 12: cursor y, registered upstream.
- left, input, 1: left button level, registered upstream.
- right, input, 1: right button level; used only when the optional feature is enabled.
- enable, input, 1: game accepts input. When low, no clicks are emitted.
- click_valid, output, 1: one-cycle pulse marking a confirmed click.
- click_id, output, 2: button hit by the click (click_id_t). Valid only while click_valid = 1, otherwise BTN_NONE.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, counter=0, latched coordinates=0, click_valid=0, click_id=BTN_NONE, busy=0. All outputs are registered.
- FSM states:
  - IDLE: on left=1 and enable=1, latch xpos/ypos, set counter=1, go to PRESS_DB.
  - PRESS_DB:
    - left=0: go to IDLE (glitch), counter=0.
    - left=1: counter++.
    - When the counter reaches DEBOUNCE_CYCLES: go to HELD, register click_valid=1 and click_id=hit(latched coords) for exactly one cycle.
  - HELD: wait for left=0; then set counter=1 and go to REL_DB.
  - REL_DB:
    - left=1: return to HELD, counter=0.
    - When the counter reaches DEBOUNCE_CYCLES with left=0: go to IDLE.
- Latency: left must be high for DEBOUNCE_CYCLES consecutive sampled cycles, counting the IDLE sampling cycle. click_valid is high on the following clock edge.
- Position used for the hit test is the one latched on press entry. Cursor movement during debounce is ignored.
- Hit test:
  - Per-region check: x0 <= x < x0+w and y0 <= y < y0+h, unsigned 12-bit compare. Bounds are precomputed as constants, so no overflow.
  - Priority HIT > STAND > DEAL. No match gives BTN_NONE.
  - A BTN_NONE click still pulses click_valid.
- enable: sampled only in IDLE. Deasserting it mid-press does not abort; the pending click is still emitted.
- Holding the button produces exactly one click; re-arming requires a debounced release.
- Counter saturates at DEBOUNCE_CYCLES, never wraps.
- Asynchronous reset mid-press discards the press. No pulse is emitted after reset release until a new full press.

Optional Feature:
- RIGHT_CANCEL_EN defined: right=1 in PRESS_DB aborts the press. The FSM goes to HELD with no pulse, so a release is required before the next click; the game uses this as "undo aim".
- RIGHT_CANCEL_EN undefined: right is ignored and left unconnected internally without warnings.

Decomposition:
- Package mouse_pkg holds:
  - typedef enum logic [1:0] click_id_t {BTN_NONE, BTN_HIT, BTN_STAND, BTN_DEAL}.
  - State enum.
  - Region constants: HIT x 100..199, y 600..649; STAND x 250..349, y 600..649; DEAL x 400..499, y 600..649 (x0/y0/w/h as localparams).
- One sub-module, button_hit_test: purely combinational. Takes x/y, returns click_id_t. Reused later by the hover/highlight logic.

Test Plan:
- DEBOUNCE_CYCLES=4, cursor (150,620), left high for 10 cycles → exactly one click_valid pulse, click_id=BTN_HIT, on the edge after the 4th high sample; busy high from cycle 1.
- left high 3 cycles, low 1, high 3, all at (300,610) → no click_valid; FSM back in IDLE each time.
- Press at (450,640), cursor moves to (150,620) during debounce → click_id=BTN_DEAL, using the latched position.
- Press at (10,10) → click_valid=1, click_id=BTN_NONE. Then release glitch 2 cycles low, 1 high, then 6 low → no second pulse; IDLE after 4 stable low cycles.
- Assert rst=0 mid-PRESS_DB at (150,620) → outputs 0 immediately (asynchronous). After release with left still high, a full 4 cycles are needed before the pulse.
- With RIGHT_CANCEL_EN: right=1 during PRESS_DB → no pulse; a new click is accepted only after release.
